rpc_tx_dispatcher: RTL and testbench
====================================

Name: rpc_tx_dispatcher

Overview:
- Upstream feeder of the CCI-P transmitter. Accepts outgoing RPCs from the NIC-side RPC pipeline with a ready/valid handshake and buffers them in a small FIFO.
- Assigns each RPC a tx flow id, by round-robin or by connection-id fold, and issues at most one RPC per cycle on the transmitter's rpc_in / rpc_in_valid / rpc_flow_id_in inputs.
- Issues only while the transmitter reports ccip_tx_ready. Keeps sent and stall statistics.

Parameters:
- NIC_ID, 0, NIC instance id; used only in simulation messages.
- LMAX_NUM_OF_FLOWS, 1, log2 of the maximum number of tx flows.
- RPC_WIDTH, 512, width of one RPC, equal to $bits(RpcIf).
- LFIFO_DEPTH, 3, log2 of the input FIFO depth (8 entries).

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  enables acceptance and issue.
- number_of_flows  in  LMAX_NUM_OF_FLOWS  highest valid flow index (flows 0..number_of_flows).
- flow_mode  in  1  0 = round-robin, 1 = connection-id fold.
- in_valid  in  1  upstream RPC valid.
- in_data  in  RPC_WIDTH  upstream RPC.
- in_conn_id  in  16  connection id of the RPC.
- in_ready  out  1  dispatcher can accept this cycle.
- ccip_tx_ready  in  1  transmitter ready (CCI-P c1 not almost full).
- rpc_out  out  RPC_WIDTH  RPC to the transmitter.
- rpc_out_valid  out  1  rpc_out qualifier, one-cycle pulse per RPC.
- rpc_flow_id_out  out  LMAX_NUM_OF_FLOWS  flow id for rpc_out.
- fifo_level_out  out  LFIFO_DEPTH+1  current FIFO occupancy.
- sent_cnt_out  out  32  RPCs issued, saturating.
- stall_cnt_out  out  32  backpressure-stall cycles, saturating.

Behaviour:
- Reset: asynchronous assertion and clearing of all state.
  - in_ready=0, rpc_out_valid=0, rpc_out=0, rpc_flow_id_out=0, fifo_level_out=0, both counters=0, round-robin pointer=0, FIFO empty.
  - Reset mid-operation discards all buffered RPCs; no partial output.
  - Release is synchronous to clk.
- Input handshake:
  - in_ready = start && (level < 2^LFIFO_DEPTH), registered from current state.
  - An RPC is accepted when in_valid && in_ready. It writes {in_data, in_conn_id} into the FIFO.
  - in_valid while in_ready=0 is a stall. Upstream holds data stable; nothing is dropped.
- Issue decision, cycle T: pop iff start && ccip_tx_ready && level>0.
  - At T+1: rpc_out_valid=1 with the popped data and flow id.
  - Otherwise rpc_out_valid=0 at T+1.
  - rpc_out keeps its last value when not valid.
- Latency: an RPC accepted at cycle T into an empty FIFO, with ccip_tx_ready high, appears on rpc_out at T+2.
  - Sustained throughput is 1 RPC/cycle.
- Simultaneous push and pop: level is unchanged.
  - A full FIFO with a pop in the same cycle still shows in_ready=0 that cycle; in_ready rises the next cycle.
- Flow assignment, computed at pop time with the current number_of_flows:
  - Round-robin: flow = rr pointer. After each pop, the pointer becomes 0 if pointer >= number_of_flows, else pointer+1.
  - Round-robin: if number_of_flows shrinks below the pointer, the next pop uses 0.
  - Fold: m = smallest all-ones mask >= number_of_flows; v = in_conn_id[LMAX_NUM_OF_FLOWS-1:0] & m.
  - Fold: flow = v if v <= number_of_flows, else v - (number_of_flows+1).
  - Fold does not advance the rr pointer.
- start deasserted: no accept and no pop. Buffered RPCs are retained and issue resumes when start returns.
- Statistics:
  - sent_cnt increments on every rpc_out_valid cycle.
  - stall_cnt increments on every cycle with start && level>0 && !ccip_tx_ready.
  - Both saturate at 32'hFFFF_FFFF.
- FIFO pointers wrap modulo 2^LFIFO_DEPTH. The level uses one extra bit to distinguish full from empty.
- Simulation: $display on each issue with NIC_ID, flow id and level.

Test Plan:
- Reset, then start=1, ccip_tx_ready=1, one RPC with data 0xA5 -> rpc_out_valid exactly 2 cycles after accept, rpc_out=0xA5, flow 0, sent_cnt=1.
- Round-robin, number_of_flows=2, 7 back-to-back RPCs -> flow ids 0,1,2,0,1,2,0 on consecutive cycles, level stays 0/1, in_ready never drops.
- Fold mode, number_of_flows=2, LMAX_NUM_OF_FLOWS=2, conn ids 0,1,2,3,7 -> flow ids 0,1,2,0,0.
- ccip_tx_ready=0, push 10 RPCs -> 8 accepted, in_ready=0 with level=8, stall_cnt counts each cycle, no rpc_out_valid. Release ready -> 8 issued in order, then the remaining 2, sent_cnt=10.
- FIFO full with simultaneous push and pop attempt -> no overwrite, in_ready returns next cycle, data order preserved.
- resetn asserted mid-burst with 5 buffered -> outputs 0 immediately (asynchronous), level=0, and after release nothing from before the reset is issued.

Source files
------------

// File: rtl/rpc_tx_dispatcher.sv
// RPC dispatcher feeding the CCI-P transmitter: buffers upstream RPCs in a small
// FIFO, tags each with a tx flow id and issues at most one per cycle.
module rpc_tx_dispatcher #(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int RPC_WIDTH         = 512,
  parameter int LFIFO_DEPTH       = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic                         flow_mode,
  input  logic                         in_valid,
  input  logic [RPC_WIDTH-1:0]         in_data,
  input  logic [15:0]                  in_conn_id,
  output logic                         in_ready,
  input  logic                         ccip_tx_ready,
  output logic [RPC_WIDTH-1:0]         rpc_out,
  output logic                         rpc_out_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic [LFIFO_DEPTH:0]         fifo_level_out,
  output logic [31:0]                  sent_cnt_out,
  output logic [31:0]                  stall_cnt_out
);

  localparam int FW    = LMAX_NUM_OF_FLOWS;
  localparam int DEPTH = 1 << LFIFO_DEPTH;

  logic [RPC_WIDTH-1:0]   r_data_mem [DEPTH];
  logic [FW-1:0]          r_conn_mem [DEPTH];
  logic [LFIFO_DEPTH-1:0] r_wr_ptr;
  logic [LFIFO_DEPTH-1:0] r_rd_ptr;
  logic [LFIFO_DEPTH:0]   r_level;
  logic                   r_live;
  logic [FW-1:0]          r_rr_ptr;
  logic [RPC_WIDTH-1:0]   r_rpc_out;
  logic                   r_rpc_valid;
  logic [FW-1:0]          r_flow;
  logic [31:0]            r_sent_cnt;
  logic [31:0]            r_stall_cnt;

  logic                   w_push;
  logic                   w_pop;
  logic [FW-1:0]          w_rd_conn;
  logic [FW-1:0]          w_mask;
  logic [FW-1:0]          w_fold_v;
  logic [FW-1:0]          w_fold_flow;
  logic [FW-1:0]          w_rr_flow;
  logic [FW-1:0]          w_flow;
  logic                   w_unused;

  // Only the low connection-id bits feed the fold; NIC_ID only tags debug output.
  assign w_unused = ^{in_conn_id[15:FW], 32'(NIC_ID)};

  // r_live keeps in_ready low while reset is asserted, whatever start does.
  assign in_ready  = r_live && start && !r_level[LFIFO_DEPTH];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = start && ccip_tx_ready && (r_level != '0);
  assign w_rd_conn = r_conn_mem[r_rd_ptr];

  always_comb begin
    w_mask = number_of_flows;
    // Smear the highest set bit downward to get the smallest all-ones cover.
    for (int unsigned i = 1; i < FW; i++) begin
      w_mask = w_mask | (w_mask >> 1);
    end
    w_fold_v    = w_rd_conn & w_mask;
    w_fold_flow = (w_fold_v <= number_of_flows) ? w_fold_v
                                                : w_fold_v - number_of_flows - 1'b1;
    w_rr_flow   = (r_rr_ptr > number_of_flows) ? '0 : r_rr_ptr;
    w_flow      = flow_mode ? w_fold_flow : w_rr_flow;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= in_data;
      r_conn_mem[r_wr_ptr] <= in_conn_id[FW-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_live      <= 1'b0;
      r_rr_ptr    <= '0;
      r_rpc_out   <= '0;
      r_rpc_valid <= 1'b0;
      r_flow      <= '0;
      r_sent_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_live      <= 1'b1;
      r_rpc_valid <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_rpc_out <= r_data_mem[r_rd_ptr];
        r_flow    <= w_flow;
        if (!flow_mode) begin
          r_rr_ptr <= (r_rr_ptr >= number_of_flows) ? '0 : r_rr_ptr + 1'b1;
        end
        if (r_sent_cnt != '1) r_sent_cnt <= r_sent_cnt + 1'b1;
      end
      if (start && (r_level != '0) && !ccip_tx_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign rpc_out         = r_rpc_out;
  assign rpc_out_valid   = r_rpc_valid;
  assign rpc_flow_id_out = r_flow;
  assign fifo_level_out  = r_level;
  assign sent_cnt_out    = r_sent_cnt;
  assign stall_cnt_out   = r_stall_cnt;

endmodule

// File: tb/tb_rpc_tx_dispatcher.sv
// Directed bench for rpc_tx_dispatcher: reset, latency, round-robin, fold,
// backpressure, full-FIFO push/pop and asynchronous mid-burst reset.
module tb_rpc_tx_dispatcher;
  localparam int LF = 2;
  localparam int RW = 64;
  localparam int LD = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [LF-1:0] number_of_flows = '0;
  logic          flow_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic [15:0]   in_conn_id = '0;
  logic          in_ready;
  logic          ccip_tx_ready = 1'b0;
  logic [RW-1:0] rpc_out;
  logic          rpc_out_valid;
  logic [LF-1:0] rpc_flow_id_out;
  logic [LD:0]   fifo_level_out;
  logic [31:0]   sent_cnt_out;
  logic [31:0]   stall_cnt_out;

  int checks = 0;
  int errors = 0;

  rpc_tx_dispatcher #(
    .NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .RPC_WIDTH(RW), .LFIFO_DEPTH(LD)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .number_of_flows(number_of_flows),
    .flow_mode(flow_mode), .in_valid(in_valid), .in_data(in_data),
    .in_conn_id(in_conn_id), .in_ready(in_ready), .ccip_tx_ready(ccip_tx_ready),
    .rpc_out(rpc_out), .rpc_out_valid(rpc_out_valid),
    .rpc_flow_id_out(rpc_flow_id_out), .fifo_level_out(fifo_level_out),
    .sent_cnt_out(sent_cnt_out), .stall_cnt_out(stall_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    resetn   = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    start = 1'b1;
    ccip_tx_ready = 1'b1;
    resetn = 1'b0;
    tick;
    tick;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (rpc_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rpc_out_valid); end
    checks++; if (rpc_out !== '0) begin errors++; $display("FAIL reset_rpc_out: got %0h expected 0", rpc_out); end
    checks++; if (rpc_flow_id_out !== '0) begin errors++; $display("FAIL reset_flow: got %0d expected 0", rpc_flow_id_out); end
    checks++; if (fifo_level_out !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level_out); end
    checks++; if (sent_cnt_out !== '0) begin errors++; $display("FAIL reset_sent: got %0d expected 0", sent_cnt_out); end
    checks++; if (stall_cnt_out !== '0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_out); end
    resetn = 1'b1;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_single_rpc;
    start = 1'b1; ccip_tx_ready = 1'b1; flow_mode = 1'b0; number_of_flows = 2'd2;
    do_reset;
    in_valid = 1'b1; in_data = 64'hA5; in_conn_id = 16'd0;
    tick;
    in_valid = 1'b0;
    checks++; if (rpc_out_valid !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %0b expected 0", rpc_out_valid); end
    checks++; if (fifo_level_out !== 4'd1) begin errors++; $display("FAIL single_t1_level: got %0d expected 1", fifo_level_out); end
    tick;
    checks++; if (rpc_out_valid !== 1'b1) begin errors++; $display("FAIL single_t2_valid: got %0b expected 1", rpc_out_valid); end
    checks++; if (rpc_out !== 64'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", rpc_out); end
    checks++; if (rpc_flow_id_out !== 2'd0) begin errors++; $display("FAIL single_flow: got %0d expected 0", rpc_flow_id_out); end
    tick;
    checks++; if (rpc_out_valid !== 1'b0) begin errors++; $display("FAIL single_t3_valid: got %0b expected 0", rpc_out_valid); end
    checks++; if (rpc_out !== 64'hA5) begin errors++; $display("FAIL single_hold: got %0h expected a5", rpc_out); end
    checks++; if (sent_cnt_out !== 32'd1) begin errors++; $display("FAIL single_sent: got %0d expected 1", sent_cnt_out); end
  endtask

  task automatic test_round_robin;
    int exp_flow [7] = '{0, 1, 2, 0, 1, 2, 0};
    int k = 0;
    int first = -1;
    int last = -1;
    start = 1'b1; ccip_tx_ready = 1'b1; flow_mode = 1'b0; number_of_flows = 2'd2;
    do_reset;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 7); in_data = 64'h100 + 64'(c); in_conn_id = 16'd0;
      tick;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready c=%0d: got %0b expected 1", c, in_ready); end
      checks++; if (fifo_level_out > 4'd1) begin errors++; $display("FAIL rr_level c=%0d: got %0d expected <=1", c, fifo_level_out); end
      if (rpc_out_valid === 1'b1) begin
        if (k < 7) begin
          checks++; if (rpc_out !== 64'h100 + 64'(k)) begin errors++; $display("FAIL rr_data k=%0d: got %0h expected %0h", k, rpc_out, 64'h100 + 64'(k)); end
          checks++; if (rpc_flow_id_out !== LF'(exp_flow[k])) begin errors++; $display("FAIL rr_flow k=%0d: got %0d expected %0d", k, rpc_flow_id_out, exp_flow[k]); end
        end
        if (first < 0) first = c;
        last = c;
        k++;
      end
    end
    in_valid = 1'b0;
    checks++; if (k !== 7) begin errors++; $display("FAIL rr_count: got %0d expected 7", k); end
    checks++; if (first !== 1) begin errors++; $display("FAIL rr_first: got %0d expected 1", first); end
    checks++; if (last - first !== 6) begin errors++; $display("FAIL rr_span: got %0d expected 6", last - first); end
  endtask

  task automatic test_fold;
    logic [15:0] conns [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd7};
    int exp_flow [5] = '{0, 1, 2, 0, 0};
    int k = 0;
    start = 1'b1; ccip_tx_ready = 1'b1; flow_mode = 1'b1; number_of_flows = 2'd2;
    do_reset;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 5); in_data = 64'h200 + 64'(c); in_conn_id = (c < 5) ? conns[c] : 16'd0;
      tick;
      if (rpc_out_valid === 1'b1) begin
        if (k < 5) begin
          checks++; if (rpc_out !== 64'h200 + 64'(k)) begin errors++; $display("FAIL fold_data k=%0d: got %0h expected %0h", k, rpc_out, 64'h200 + 64'(k)); end
          checks++; if (rpc_flow_id_out !== LF'(exp_flow[k])) begin errors++; $display("FAIL fold_flow k=%0d: got %0d expected %0d", k, rpc_flow_id_out, exp_flow[k]); end
        end
        k++;
      end
    end
    in_valid = 1'b0;
    checks++; if (k !== 5) begin errors++; $display("FAIL fold_count: got %0d expected 5", k); end
    // Fold pops leave the round-robin pointer at 0.
    flow_mode = 1'b0;
    in_valid = 1'b1; in_data = 64'h2AA; in_conn_id = 16'd3;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (rpc_out_valid !== 1'b1) begin errors++; $display("FAIL fold_rr_valid: got %0b expected 1", rpc_out_valid); end
    checks++; if (rpc_flow_id_out !== 2'd0) begin errors++; $display("FAIL fold_rr_flow: got %0d expected 0", rpc_flow_id_out); end
  endtask

  task automatic test_backpressure;
    int exp_flow [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int idx = 0;
    int got = 0;
    logic rdy;
    logic acc;
    start = 1'b1; ccip_tx_ready = 1'b0; flow_mode = 1'b0; number_of_flows = 2'd2;
    do_reset;
    rdy = in_ready;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 10); in_data = 64'h300 + 64'(idx);
      acc = in_valid && rdy;
      tick;
      if (acc) idx++;
      checks++; if (rpc_out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_valid c=%0d: got %0b expected 0", c, rpc_out_valid); end
      rdy = in_ready;
    end
    checks++; if (idx !== 8) begin errors++; $display("FAIL bp_accepted: got %0d expected 8", idx); end
    checks++; if (fifo_level_out !== 4'd8) begin errors++; $display("FAIL bp_level: got %0d expected 8", fifo_level_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b expected 0", in_ready); end
    checks++; if (stall_cnt_out !== 32'd11) begin errors++; $display("FAIL bp_stall: got %0d expected 11", stall_cnt_out); end
    ccip_tx_ready = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      in_valid = (idx < 10); in_data = 64'h300 + 64'(idx);
      acc = in_valid && rdy;
      tick;
      if (acc) idx++;
      if (rpc_out_valid === 1'b1) begin
        checks++; if (rpc_out !== 64'h300 + 64'(got)) begin errors++; $display("FAIL bp_data k=%0d: got %0h expected %0h", got, rpc_out, 64'h300 + 64'(got)); end
        checks++; if (rpc_flow_id_out !== LF'(exp_flow[got])) begin errors++; $display("FAIL bp_flow k=%0d: got %0d expected %0d", got, rpc_flow_id_out, exp_flow[got]); end
        got++;
      end
      rdy = in_ready;
    end
    in_valid = 1'b0;
    checks++; if (got !== 10) begin errors++; $display("FAIL bp_drained: got %0d expected 10", got); end
    tick;
    checks++; if (sent_cnt_out !== 32'd10) begin errors++; $display("FAIL bp_sent: got %0d expected 10", sent_cnt_out); end
    checks++; if (stall_cnt_out !== 32'd11) begin errors++; $display("FAIL bp_stall_final: got %0d expected 11", stall_cnt_out); end
    checks++; if (fifo_level_out !== 4'd0) begin errors++; $display("FAIL bp_level_final: got %0d expected 0", fifo_level_out); end
  endtask

  task automatic test_full_push_pop;
    logic [RW-1:0] exp_data [9];
    int got = 2;
    start = 1'b1; ccip_tx_ready = 1'b0; flow_mode = 1'b0; number_of_flows = 2'd2;
    do_reset;
    for (int c = 0; c < 8; c++) begin
      exp_data[c] = 64'h400 + 64'(c);
      in_valid = 1'b1; in_data = 64'h400 + 64'(c);
      tick;
    end
    exp_data[8] = 64'h4FF;
    checks++; if (fifo_level_out !== 4'd8) begin errors++; $display("FAIL full_level: got %0d expected 8", fifo_level_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
    ccip_tx_ready = 1'b1; in_valid = 1'b1; in_data = 64'h4FF;
    tick;
    checks++; if (fifo_level_out !== 4'd7) begin errors++; $display("FAIL full_pop_level: got %0d expected 7", fifo_level_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %0b expected 1", in_ready); end
    checks++; if (rpc_out !== 64'h400) begin errors++; $display("FAIL full_first: got %0h expected 400", rpc_out); end
    tick;
    in_valid = 1'b0;
    checks++; if (fifo_level_out !== 4'd7) begin errors++; $display("FAIL full_pushpop_level: got %0d expected 7", fifo_level_out); end
    checks++; if (rpc_out !== 64'h401) begin errors++; $display("FAIL full_second: got %0h expected 401", rpc_out); end
    for (int c = 0; c < 20 && got < 9; c++) begin
      tick;
      if (rpc_out_valid === 1'b1) begin
        checks++; if (rpc_out !== exp_data[got]) begin errors++; $display("FAIL full_order k=%0d: got %0h expected %0h", got, rpc_out, exp_data[got]); end
        got++;
      end
    end
    checks++; if (got !== 9) begin errors++; $display("FAIL full_drained: got %0d expected 9", got); end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; ccip_tx_ready = 1'b0; flow_mode = 1'b0; number_of_flows = 2'd2;
    do_reset;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 64'h500 + 64'(c);
      tick;
    end
    in_valid = 1'b0;
    checks++; if (fifo_level_out !== 4'd5) begin errors++; $display("FAIL mid_level5: got %0d expected 5", fifo_level_out); end
    ccip_tx_ready = 1'b1;
    tick;
    checks++; if (rpc_out !== 64'h500) begin errors++; $display("FAIL mid_pre_data: got %0h expected 500", rpc_out); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (rpc_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", rpc_out_valid); end
    checks++; if (rpc_out !== '0) begin errors++; $display("FAIL mid_data: got %0h expected 0", rpc_out); end
    checks++; if (fifo_level_out !== '0) begin errors++; $display("FAIL mid_level: got %0d expected 0", fifo_level_out); end
    checks++; if (sent_cnt_out !== '0) begin errors++; $display("FAIL mid_sent: got %0d expected 0", sent_cnt_out); end
    checks++; if (stall_cnt_out !== '0) begin errors++; $display("FAIL mid_stall: got %0d expected 0", stall_cnt_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %0b expected 0", in_ready); end
    #2;
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      checks++; if (rpc_out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_issue c=%0d: got %0b expected 0", c, rpc_out_valid); end
    end
    in_valid = 1'b1; in_data = 64'h5AA;
    tick;
    in_valid = 1'b0;
    tick;
    checks++; if (rpc_out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %0b expected 1", rpc_out_valid); end
    checks++; if (rpc_out !== 64'h5AA) begin errors++; $display("FAIL mid_new_data: got %0h expected 5aa", rpc_out); end
    checks++; if (rpc_flow_id_out !== 2'd0) begin errors++; $display("FAIL mid_new_flow: got %0d expected 0", rpc_flow_id_out); end
    checks++; if (sent_cnt_out !== 32'd1) begin errors++; $display("FAIL mid_new_sent: got %0d expected 1", sent_cnt_out); end
  endtask

  initial begin
    test_reset;
    test_single_rpc;
    test_round_robin;
    test_fold;
    test_backpressure;
    test_full_push_pop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
